// File: rtl/bram_fifo_ctrl.sv
// Single-clock first-word-fall-through FIFO controller for an external dual-port BRAM, with a
// 2-entry output skid buffer. Defining BRAM_FIFO_LEVEL_EN adds the registered `level` output.
module bram_fifo_ctrl #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 512,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              ram_wr_en,
    output logic [AW-1:0]     ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_rd_en,
    output logic [AW-1:0]     ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              full,
    output logic              empty
`ifdef BRAM_FIFO_LEVEL_EN
    ,
    output logic [AW+1:0]     level
`endif
);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [1:0]        ob_cnt;
    logic [1:0]        ob_cnt_next;
    logic              inflight;
    logic              ram_empty;
    logic              push;
    logic              pop;
    logic              fill_to_head;
    logic [DATA_W-1:0] ob_data [2];

    assign ram_empty = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = ram_empty && !inflight && (ob_cnt == 2'd0);

    assign s_ready     = !full && !rst;
    assign push        = s_valid && s_ready;
    assign ram_wr_en   = push;
    assign ram_wr_addr = wr_ptr[AW-1:0];
    assign ram_wr_data = s_data;

    assign m_valid = (ob_cnt != 2'd0);
    assign m_data  = ob_data[0];
    assign pop     = m_valid && m_ready;

    // Buffer occupancy after this edge; a new read may only be issued if its word will fit.
    assign ob_cnt_next  = ob_cnt + 2'(inflight) - 2'(pop);
    assign ram_rd_en    = !ram_empty && !rst && (ob_cnt_next < 2'd2);
    assign ram_rd_addr  = rd_ptr[AW-1:0];
    assign fill_to_head = (ob_cnt == 2'(pop));

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ob_cnt   <= 2'd0;
            inflight <= 1'b0;
        end else begin
            if (push)      wr_ptr <= wr_ptr + PTR_ONE;
            if (ram_rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            inflight <= ram_rd_en;
            ob_cnt   <= ob_cnt_next;
        end
    end

    // NOTE: the skid-buffer data registers carry no reset; ob_cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (pop) ob_data[0] <= ob_data[1];
        if (inflight) begin
            if (fill_to_head) ob_data[0] <= ram_rd_data;
            else              ob_data[1] <= ram_rd_data;
        end
    end

`ifdef BRAM_FIFO_LEVEL_EN
    // Total held words change only through the producer and consumer handshakes.
    always_ff @(posedge clk) begin
        if (rst) level <= '0;
        else     level <= level + (AW+2)'(push) - (AW+2)'(pop);
    end
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl with a behavioural 1-cycle-latency BRAM and a
// scoreboard queue of accepted words compared against words popped from the consumer side.
module tb_bram_fifo_ctrl;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              ram_wr_en;
    logic [AW-1:0]     ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ram_rd_en;
    logic [AW-1:0]     ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              full;
    logic              empty;
`ifdef BRAM_FIFO_LEVEL_EN
    logic [AW+1:0]     level;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q [$];
    int                ram_cnt = 0;
    logic [AW-1:0]     exp_wr_addr = '0;
    logic [AW-1:0]     exp_rd_addr = '0;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              obs_m_valid, obs_empty, obs_full, obs_s_ready;
    logic              obs_wr_en, obs_rd_en, obs_accept, obs_pop;
    logic [DATA_W-1:0] obs_m_data;

    always #5 clk = ~clk;

    bram_fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .full        (full),
        .empty       (empty)
`ifdef BRAM_FIFO_LEVEL_EN
        ,
        .level       (level)
`endif
    );

    // Behavioural BRAM: registered read, one cycle of latency.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    // One clock cycle: sample at the falling edge, score handshakes, advance the reference model.
    task automatic cycle();
        logic acc;
        logic rdi;
        logic [DATA_W-1:0] exp_word;
        @(negedge clk);
        obs_m_valid = m_valid;
        obs_empty   = empty;
        obs_full    = full;
        obs_s_ready = s_ready;
        obs_wr_en   = ram_wr_en;
        obs_rd_en   = ram_rd_en;
        obs_m_data  = m_data;
        acc         = s_valid && s_ready;
        rdi         = ram_rd_en;
        obs_accept  = acc;
        obs_pop     = m_valid && m_ready;

        checks++;
        if (ram_wr_en !== acc || (acc && (ram_wr_addr !== exp_wr_addr || ram_wr_data !== s_data))) begin
            errors++;
            $display("FAIL wr_port: en=%0b addr=%0d data=%h, required en=%0b addr=%0d data=%h",
                     ram_wr_en, ram_wr_addr, ram_wr_data, acc, exp_wr_addr, s_data);
        end
        checks++;
        if (full !== (ram_cnt == DEPTH)) begin
            errors++;
            $display("FAIL full_flag: got %0b, required %0b (ram count %0d)", full, ram_cnt == DEPTH, ram_cnt);
        end
        if (rdi) begin
            checks++;
            if (ram_cnt == 0 || ram_rd_addr !== exp_rd_addr) begin
                errors++;
                $display("FAIL rd_port: addr=%0d ram_count=%0d, required addr=%0d with non-empty RAM",
                         ram_rd_addr, ram_cnt, exp_rd_addr);
            end
        end
`ifdef BRAM_FIFO_LEVEL_EN
        checks++;
        if (level !== (AW+2)'(exp_q.size())) begin
            errors++;
            $display("FAIL level: got %0d, required %0d", level, exp_q.size());
        end
`endif
        if (obs_pop) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_underflow: got word %h, required no output word", m_data);
            end else begin
                exp_word = exp_q.pop_front();
                if (m_data !== exp_word) begin
                    errors++;
                    $display("FAIL out_data: got %h, required %h", m_data, exp_word);
                end
            end
        end
        if (acc) exp_q.push_back(s_data);

        @(posedge clk);
        if (rst) begin
            ram_cnt     = 0;
            exp_wr_addr = '0;
            exp_rd_addr = '0;
            exp_q.delete();
        end else begin
            if (acc) begin ram_cnt++; exp_wr_addr++; end
            if (rdi) begin ram_cnt--; exp_rd_addr++; end
        end
        #1;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words left, required 0", exp_q.size());
        end
        repeat (3) cycle();
        checks++;
        if (obs_empty !== 1'b1 || obs_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL drained_empty: empty=%0b m_valid=%0b, required empty=1 m_valid=0", obs_empty, obs_m_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; s_data = 32'h1234_5678; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cycle();
        checks++;
        if ({obs_m_valid, obs_empty, obs_full} !== 3'b010) begin
            errors++;
            $display("FAIL reset_flags: m_valid/empty/full=%b, required 010", {obs_m_valid, obs_empty, obs_full});
        end
        checks++;
        if ({obs_s_ready, obs_wr_en, obs_rd_en} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ports: s_ready/wr_en/rd_en=%b, required 000", {obs_s_ready, obs_wr_en, obs_rd_en});
        end
        rst = 1'b0; s_valid = 1'b0;
        cycle();
        checks++;
        if (obs_s_ready !== 1'b1 || obs_empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: s_ready=%0b empty=%0b, required 1 1", obs_s_ready, obs_empty);
        end
    endtask

    task automatic test_first_word();
        s_valid = 1'b1; s_data = 32'hA5A5_0001; m_ready = 1'b1;
        cycle();
        checks++;
        if (obs_accept !== 1'b1) begin
            errors++;
            $display("FAIL first_accept: got %0b, required 1", obs_accept);
        end
        s_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            checks++;
            if (obs_m_valid !== (k == 3)) begin
                errors++;
                $display("FAIL first_latency: cycle %0d m_valid=%0b, required %0b", k, obs_m_valid, k == 3);
            end
        end
        checks++;
        if (obs_m_data !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL first_data: got %h, required a5a50001", obs_m_data);
        end
        cycle();
        checks++;
        if (obs_empty !== 1'b1 || obs_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_empty: empty=%0b m_valid=%0b, required 1 0", obs_empty, obs_m_valid);
        end
    endtask

    task automatic test_fill_full();
        int n_acc;
        int n_pop;
        n_acc = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            s_valid = 1'b1; s_data = 32'h0000_1000 + i;
            cycle();
            if (obs_accept) n_acc++;
        end
        checks++;
        if (n_acc != DEPTH + 2) begin
            errors++;
            $display("FAIL fill_count: got %0d, required %0d", n_acc, DEPTH + 2);
        end
        checks++;
        if (obs_full !== 1'b1 || obs_s_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_flags: full=%0b s_ready=%0b, required 1 0", obs_full, obs_s_ready);
        end
`ifdef BRAM_FIFO_LEVEL_EN
        checks++;
        if (level !== 5'd10) begin
            errors++;
            $display("FAIL fill_level: got %0d, required 10", level);
        end
`endif
        // Full: pop and offer a push every cycle; the full-flag invariant is scored each cycle.
        n_pop = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1; s_data = 32'h0000_2000 + i;
            cycle();
            if (obs_pop) n_pop++;
        end
        checks++;
        if (n_pop != 12) begin
            errors++;
            $display("FAIL full_pop_rate: got %0d pops, required 12", n_pop);
        end
        drain();
    endtask

    task automatic test_stream();
        int n_acc;
        int n_pop;
        int gaps;
        bit started;
        n_acc = 0; n_pop = 0; gaps = 0; started = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            s_valid = 1'b1; s_data = 32'h0001_0000 + i;
            cycle();
            if (obs_accept) n_acc++;
            if (obs_pop) begin n_pop++; started = 1'b1; end
            else if (started) gaps++;
        end
        checks++;
        if (n_acc != 1000 || n_pop != 997) begin
            errors++;
            $display("FAIL stream_rate: accepted %0d popped %0d, required 1000 997", n_acc, n_pop);
        end
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL stream_gaps: got %0d, required 0", gaps);
        end
        drain();
    endtask

    task automatic test_random();
        int n_acc;
        n_acc = 0;
        for (int i = 0; i < 10000; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data  = $urandom;
            cycle();
            if (obs_accept) n_acc++;
        end
        checks++;
        if (n_acc < 1000) begin
            errors++;
            $display("FAIL random_accepts: got %0d, required at least 1000", n_acc);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        int n_acc;
        int stale;
        n_acc = 0; stale = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 20 && n_acc < 6; i++) begin
            s_valid = 1'b1; s_data = 32'hDEAD_0000 + i;
            cycle();
            if (obs_accept) n_acc++;
        end
        s_valid = 1'b0;
        repeat (3) cycle();
        m_ready = 1'b1;
        cycle();
        checks++;
        if (obs_pop !== 1'b1 || obs_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: pop=%0b rd_en=%0b, required 1 1", obs_pop, obs_rd_en);
        end
        m_ready = 1'b0; rst = 1'b1;
        cycle();
        checks++;
        if (obs_rd_en !== 1'b0 || obs_s_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_ports: rd_en=%0b s_ready=%0b, required 0 0", obs_rd_en, obs_s_ready);
        end
        rst = 1'b0; m_ready = 1'b1;
        cycle();
        checks++;
        if (obs_m_valid !== 1'b0 || obs_empty !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_state: m_valid=%0b empty=%0b, required 0 1", obs_m_valid, obs_empty);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (obs_m_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL mid_rst_stale: %0d cycles with m_valid, required 0", stale);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_word();
        test_fill_full();
        test_stream();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_fifo_ctrl.md
# bram_fifo_ctrl

Single-clock FIFO controller that owns the write and read ports of an external `bram_dual_port` instance, with both BRAM clock inputs tied to `clk`. It turns a valid/ready producer stream into BRAM writes, and turns 1-cycle-latency BRAM reads into a first-word-fall-through valid/ready consumer stream. A 2-entry output skid buffer sustains one word per cycle. The block sits between pipeline stages that need deep elastic buffering.

## Interface
- `DATA_W`, 32: word width; matches the BRAM `RAM_WIDTH`.
- `DEPTH`, 512: BRAM word count; must be a power of two, ≥ 4.
- `AW`, `$clog2(DEPTH)`: BRAM address width; derived, not overridden.

Ports:
- `clk` in 1: single clock. Both BRAM clocks are tied to it.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: producer word valid.
- `s_ready` out 1: block can accept a word.
- `s_data` in `DATA_W`: producer word.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: consumer accepts the word.
- `m_data` out `DATA_W`: output word (head of the skid buffer).
- `ram_wr_en` out 1: drives BRAM `wr_ena`.
- `ram_wr_addr` out `AW`: drives BRAM `addra`.
- `ram_wr_data` out `DATA_W`: drives BRAM `dina`.
- `ram_rd_en` out 1: drives BRAM `rd_enb`.
- `ram_rd_addr` out `AW`: drives BRAM `addrb`.
- `ram_rd_data` in `DATA_W`: from BRAM `doutb`.
- `full` out 1: the RAM holds `DEPTH` words.
- `empty` out 1: no word is anywhere in the block (RAM, in flight, or output buffer).
- `level` out `AW+2`: total words held. Present only with `BRAM_FIFO_LEVEL_EN`.

## Operation
**Pointers**
- `wr_ptr` and `rd_ptr` are `AW+1` bits wide. The MSB is the wrap bit.
- RAM count = `wr_ptr - rd_ptr`, taken modulo 2^(AW+1).
- `full` = low AW bits equal and MSBs differ.
- RAM empty = pointers equal.

**Write path**
- `s_ready = !full && !rst`.
- Push = `s_valid && s_ready`.
- On push: `ram_wr_en=1`, `ram_wr_addr=wr_ptr[AW-1:0]`, `ram_wr_data=s_data`. `wr_ptr` increments and wraps naturally.

**Read path**
- `inflight` flag: set for exactly one cycle after each `ram_rd_en`.
- `ob_cnt` is the skid-buffer occupancy, 0..2.
- Pop = `m_valid && m_ready`.
- Issue a read when all three hold:
  - RAM is not empty;
  - `!rst`;
  - `ob_cnt + inflight - pop < 2`.
- On issue: `ram_rd_en=1`, `ram_rd_addr=rd_ptr[AW-1:0]`. `rd_ptr` increments.
- When `inflight` is set, `ram_rd_data` is written into the skid buffer in FIFO order.
- `m_valid = (ob_cnt != 0)`. `m_data` = oldest buffer entry.

**Simultaneous events and ordering**
- Push and issue in the same cycle are legal. The pointers differ, so there is no address collision.
- Read issue uses registered pointers only. A word written at edge E is never read before the cycle after E.
- Pop and buffer fill in the same cycle leave `ob_cnt` unchanged.
- Effective capacity = `DEPTH` + 2 words.
- Overflow is impossible by construction. Underflow is impossible because `m_valid` gates the pop.

## Timing
**Reset values** (rst high at an edge): after that edge,
- `wr_ptr=rd_ptr=0`, `ob_cnt=0`, `inflight=0`;
- `m_valid=0`, `full=0`, `empty=1`, `level=0`;
- `s_ready=0`, `ram_wr_en=0` and `ram_rd_en=0` while `rst` is high.

Mid-operation reset discards all contents. Any BRAM read in flight is ignored.

**Latency**
- Word accepted at edge E0 → `ram_rd_en` asserted in cycle E0..E1 → captured at E2.
- `m_valid` is high from E2: first-word latency is 2 cycles when the block was empty.

**Throughput and flags**
- Steady state: one push and one pop per cycle, indefinitely, with `m_ready=1`.
- `full` and `empty` are registered-state derived; there is no combinational path from `s_valid` or `m_ready`.
- `s_ready` is combinational only from `rst` and the registered pointers. `ram_rd_en` combinationally depends on `m_ready`.

## Configuration
- `BRAM_FIFO_LEVEL_EN` defined:
  - `level` output exists.
  - `level` = RAM count + `inflight` + `ob_cnt`, registered and updated every cycle.
  - `level` is 0 in reset; maximum is `DEPTH+2`.
- Not defined: the `level` port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset, then one push of `0xA5A5_0001` with `m_ready=1`. Required: `m_valid` rises exactly 2 cycles after the accept edge with `m_data=0xA5A5_0001`; `empty` returns to 1 the cycle after the pop.
- `m_ready=0`, push continuously with `DEPTH=8`. Required: 10 words accepted (8 RAM + 2 buffer); `full=1`; `s_ready=0`; `level=10`.
- Continuous push and pop of an incrementing sequence for 1000 cycles. Required: output strictly increments, no gaps after the initial 2-cycle fill, pointers wrap cleanly.
- Random `s_valid` and `m_ready` at 50% each for 10k cycles. Required: output sequence equals input sequence; `ram_rd_en` is never asserted while RAM is empty.
- Assert `rst` for 1 cycle while the block holds 5 words with a read in flight. Required: the next cycle shows `m_valid=0`, `empty=1`, `level=0`; the stale `ram_rd_data` is never presented.
- With `DEPTH=8`, fill to 8, then pop and push in the same cycle. Required: `full` stays 1 only while the RAM count is 8; no word is lost or duplicated.
